itf_piso_buf: RTL and testbench
===============================

Name: itf_piso_buf

Overview:
- Buffered parallel-in/serial-out width converter on the on-chip→off-chip path of the interface unit.
- Accepts DATA_IN_WIDTH-bit words from the global-buffer read ports and emits DATA_OUT_WIDTH-bit beats toward the pad.
- Preserves word-level LAST as beat-level LAST.
- A small word FIFO decouples SRAM read bursts from pad back-pressure, so IN_RDY stays high across consecutive words.

Parameters:
- DATA_IN_WIDTH, 256: input word width.
- DATA_OUT_WIDTH, 128: output beat width. DATA_IN_WIDTH must be an integer multiple R >= 1 of DATA_OUT_WIDTH.
- DEPTH, 2: word FIFO entries, >= 1, power of two.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- IN_DAT  in  DATA_IN_WIDTH  input word
- IN_VLD  in  1  input word valid
- IN_LAST  in  1  word is last of transfer
- IN_RDY  out  1  block can accept a word
- OUT_DAT  out  DATA_OUT_WIDTH  output beat
- OUT_VLD  out  1  beat valid
- OUT_LAST  out  1  final beat of the final word
- OUT_RDY  in  1  downstream accepts beat
- BUSY  out  1  any word held or in serialization

Behaviour:
- Reset (rst=1 at a rising edge): FIFO emptied, beat counter=0.
  - Next-cycle outputs: IN_RDY=1, OUT_VLD=0, OUT_LAST=0, BUSY=0, OUT_DAT=0.
  - Reset mid-transfer discards all held words and partial beats; no LAST is emitted for them.
- Input handshake: word accepted when IN_VLD & IN_RDY at a rising edge.
  - IN_RDY = (count < DEPTH), registered-state based only. It has no combinational dependence on OUT_RDY.
  - With the FIFO full, a word is not accepted even if the head completes in the same cycle. IN_RDY rises the cycle after.
- Word FIFO: DEPTH entries of {data, last}; write/read pointers wrap modulo DEPTH.
  - count is updated +1 on accept only, -1 on head retire only, and unchanged on simultaneous accept and retire.
- Serializer: beat counter k in 0..R-1 over the FIFO head.
  - OUT_VLD = FIFO not empty.
  - OUT_DAT = head.data[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH], lowest slice first.
  - OUT_LAST = OUT_VLD & head.last & (k == R-1).
  - Beat transfer occurs on OUT_VLD & OUT_RDY. It increments k; at k=R-1 it sets k=0 and retires the head.
  - OUT_VLD, once asserted, is held with OUT_DAT/OUT_LAST stable until the transfer (AXI-style). OUT_VLD never depends on OUT_RDY.
- Latency: word accepted at edge t, FIFO previously empty → first beat OUT_VLD=1 after edge t (one cycle). No combinational IN→OUT path.
- Throughput:
  - R=1 with DEPTH>=2: one word per cycle sustained.
  - R>1: one beat per cycle while OUT_RDY=1, with no bubble between words.
- States (derived from count and k, no separate encoding required):
  - EMPTY: count=0.
  - SHIFT: count>0. Stays in SHIFT while count>0; returns to EMPTY when the last beat of the last held word transfers and no new word is accepted.
  - FULL: count=DEPTH, a sub-case of SHIFT with IN_RDY=0.
- IN_LAST of a word is carried with that word only. There is no transfer-level state, so back-to-back transfers need no idle gap.
- BUSY = (count != 0).

Optional Feature:
- Macro: ITF_PISO_MSB_FIRST_EN
- Defined: slice order reversed. Beat k carries IN_DAT[(R-1-k)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH], so the most-significant slice goes first. LAST still marks beat k=R-1.
- Not defined: least-significant slice first, as in Behaviour.

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, IN_VLD=1 → IN_RDY=1, OUT_VLD=0, BUSY=0 after release; no word captured during reset.
- Single word, R=2:
  - Stimulus: IN_DAT={128'hB,128'hA}, IN_LAST=1, OUT_RDY=1.
  - Response: beats 128'hA (LAST=0) then 128'hB (LAST=1) on consecutive cycles, first beat one cycle after accept; BUSY low after the second beat.
- Back-pressure:
  - Stimulus: stream 4 words, DEPTH=2, OUT_RDY=0.
  - Response: exactly 2 words accepted, then IN_RDY=0. OUT_DAT stays stable on 1st slice of word 0.
  - Then OUT_RDY=1: 8 beats in order, no bubbles; LAST only on beat 8 when word 3 has IN_LAST=1.
- Full + simultaneous retire: FIFO full, last beat of head transfers while IN_VLD=1 → word not accepted that cycle; IN_RDY=1 next cycle; count never exceeds DEPTH.
- Reset mid-transfer: after 1 of 2 beats of a LAST word, pulse rst=1 → next cycle OUT_VLD=0, BUSY=0; no OUT_LAST ever observed for that word.
- Macro on (ITF_PISO_MSB_FIRST_EN), R=2, IN_DAT={128'hB,128'hA} → beats 128'hB then 128'hA (LAST=1 on 'hA).

Source files
------------

// File: rtl/itf_piso_buf.sv
// -----------------------------------------------------------------------------
// itf_piso_buf
//
// Buffered parallel-in / serial-out width converter for the on-chip to
// off-chip path of the interface unit. DATA_IN_WIDTH-bit words from the
// global-buffer read ports are held in a small word FIFO and emitted as
// R = DATA_IN_WIDTH / DATA_OUT_WIDTH beats of DATA_OUT_WIDTH bits toward the
// pad. Word-level LAST becomes beat-level LAST on the final beat of the word.
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous reset, active-high
//   IN_DAT    in   input word
//   IN_VLD    in   input word valid
//   IN_LAST   in   word is the last of its transfer
//   IN_RDY    out  block can accept a word (registered state only)
//   OUT_DAT   out  output beat (zero while no beat is valid)
//   OUT_VLD   out  beat valid
//   OUT_LAST  out  final beat of the final word
//   OUT_RDY   in   downstream accepts beat
//   BUSY      out  any word held or in serialization
//
// Parameters
//   DATA_IN_WIDTH   input word width, integer multiple (R >= 1) of DATA_OUT_WIDTH
//   DATA_OUT_WIDTH  output beat width
//   DEPTH           word FIFO entries, >= 1, power of two
//
// Build option
//   ITF_PISO_MSB_FIRST_EN  when defined, the most-significant slice of each
//                          word is sent first; LAST still marks the final beat.
//                          Default: least-significant slice first.
//
// State table (derived from the word count, no separate state register)
//   state    | meaning
//   EMPTY    | no word held, OUT_VLD low
//   SHIFT    | at least one word held, head being serialized
//   FULL     | DEPTH words held (sub-case of SHIFT), IN_RDY low
// -----------------------------------------------------------------------------
module itf_piso_buf #(
    parameter int DATA_IN_WIDTH  = 256,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_IN_WIDTH-1:0]  IN_DAT,
    input  logic                      IN_VLD,
    input  logic                      IN_LAST,
    output logic                      IN_RDY,
    output logic [DATA_OUT_WIDTH-1:0] OUT_DAT,
    output logic                      OUT_VLD,
    output logic                      OUT_LAST,
    input  logic                      OUT_RDY,
    output logic                      BUSY
);

    localparam int R  = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = (R > 1) ? $clog2(R) : 1;

    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [KW-1:0] BEAT_MAX = KW'(R - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // storage
    logic [DATA_IN_WIDTH-1:0] r_mem_dat  [DEPTH];
    logic                     r_mem_last [DEPTH];

    // control state
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [KW-1:0] r_beat;

    // next-state values
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [KW-1:0] w_beat_nxt;

    state_t                    w_state;
    logic                      w_in_rdy;
    logic                      w_out_vld;
    logic                      w_push;
    logic                      w_beat_xfer;
    logic                      w_beat_end;
    logic                      w_pop;
    logic [DATA_IN_WIDTH-1:0]  w_head_dat;
    logic                      w_head_last;
    logic [KW-1:0]             w_slice_sel;
    logic [DATA_OUT_WIDTH-1:0] w_slice;

    // -------------------------------------------------------------------------
    // State decode from the registered word count. IN_RDY and OUT_VLD come
    // only from registered state, so neither has a path from OUT_RDY or IN_VLD.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state = ST_SHIFT;
        if (r_count == '0) begin
            w_state = ST_EMPTY;
        end else if (r_count == CNT_FULL) begin
            w_state = ST_FULL;
        end
    end

    assign w_in_rdy    = (w_state != ST_FULL);
    assign w_out_vld   = (w_state != ST_EMPTY);
    assign w_push      = IN_VLD & w_in_rdy;
    assign w_beat_xfer = w_out_vld & OUT_RDY;
    assign w_beat_end  = (r_beat == BEAT_MAX);
    assign w_pop       = w_beat_xfer & w_beat_end;

    // -------------------------------------------------------------------------
    // Next-state logic. When full, a retiring head does not open a slot in
    // the same cycle: w_push is already gated by the registered FULL state.
    // -------------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_beat_nxt   = r_beat;

        if (w_push) begin
            w_wr_ptr_nxt = (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + PW'(1);
        end

        if (w_pop) begin
            w_rd_ptr_nxt = (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + PW'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        if (w_beat_xfer) begin
            w_beat_nxt = w_beat_end ? '0 : r_beat + KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_beat   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_beat   <= w_beat_nxt;
        end
    end

    // Entry contents are don't-care while not counted as held, so the array
    // needs no reset; OUT_DAT is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr_ptr]  <= IN_DAT;
            r_mem_last[r_wr_ptr] <= IN_LAST;
        end
    end

    // -------------------------------------------------------------------------
    // Serializer output: pick slice of the head word for the current beat.
    // -------------------------------------------------------------------------
    assign w_head_dat  = r_mem_dat[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];

`ifdef ITF_PISO_MSB_FIRST_EN
    assign w_slice_sel = BEAT_MAX - r_beat;
`else
    assign w_slice_sel = r_beat;
`endif

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < R; i++) begin
            if (w_slice_sel == KW'(i)) begin
                w_slice = w_head_dat[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
            end
        end
    end

    assign IN_RDY   = w_in_rdy;
    assign OUT_VLD  = w_out_vld;
    assign OUT_DAT  = w_out_vld ? w_slice : '0;
    assign OUT_LAST = w_out_vld & w_head_last & w_beat_end;
    assign BUSY     = w_out_vld;

endmodule

// File: tb/tb_itf_piso_buf.sv
module tb_itf_piso_buf;

    localparam int DIN   = 256;
    localparam int DOUT  = 128;
    localparam int DEPTH = 2;
    localparam int R     = DIN / DOUT;

    logic            clk;
    logic            rst;
    logic [DIN-1:0]  IN_DAT;
    logic            IN_VLD;
    logic            IN_LAST;
    logic            IN_RDY;
    logic [DOUT-1:0] OUT_DAT;
    logic            OUT_VLD;
    logic            OUT_LAST;
    logic            OUT_RDY;
    logic            BUSY;

    itf_piso_buf #(
        .DATA_IN_WIDTH (DIN),
        .DATA_OUT_WIDTH(DOUT),
        .DEPTH         (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .IN_DAT  (IN_DAT),
        .IN_VLD  (IN_VLD),
        .IN_LAST (IN_LAST),
        .IN_RDY  (IN_RDY),
        .OUT_DAT (OUT_DAT),
        .OUT_VLD (OUT_VLD),
        .OUT_LAST(OUT_LAST),
        .OUT_RDY (OUT_RDY),
        .BUSY    (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DOUT-1:0] act, input logic [DOUT-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of held words ----------------
    logic [DIN-1:0] mq_dat[$];
    bit             mq_last[$];
    int             mk = 0;
    bit             model_live = 0;
    bit             m_push, m_fire;
    int             cyc = 0;

    function automatic logic [DOUT-1:0] slice_of(input logic [DIN-1:0] w, input int k);
        int idx;
`ifdef ITF_PISO_MSB_FIRST_EN
        idx = R - 1 - k;
`else
        idx = k;
`endif
        return w[idx*DOUT +: DOUT];
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq_dat.delete();
            mq_last.delete();
            mk = 0;
            model_live = 1;
        end else if (model_live) begin
            m_push = IN_VLD && (mq_dat.size() < DEPTH);
            m_fire = (mq_dat.size() > 0) && OUT_RDY;
            if (m_fire) begin
                if (mk == R - 1) begin
                    mk = 0;
                    void'(mq_dat.pop_front());
                    void'(mq_last.pop_front());
                end else begin
                    mk++;
                end
            end
            if (m_push) begin
                mq_dat.push_back(IN_DAT);
                mq_last.push_back(IN_LAST);
            end
        end
    end

    // ---------------- per-cycle compare and transfer log ----------------
    logic [DOUT-1:0] log_dat[$];
    bit              log_last[$];
    int              log_cyc[$];
    int              acc_cnt = 0;

    always @(negedge clk) begin
        if (model_live) begin
            logic            e_vld;
            logic [DOUT-1:0] e_dat;
            logic            e_last;
            e_vld  = (mq_dat.size() > 0);
            e_dat  = e_vld ? slice_of(mq_dat[0], mk) : '0;
            e_last = e_vld && mq_last[0] && (mk == R - 1);
            chk("cyc_in_rdy",   IN_RDY,   (mq_dat.size() < DEPTH));
            chk("cyc_out_vld",  OUT_VLD,  e_vld);
            chk("cyc_out_dat",  OUT_DAT,  e_dat);
            chk("cyc_out_last", OUT_LAST, e_last);
            chk("cyc_busy",     BUSY,     e_vld);
        end
        if (!rst && OUT_VLD && OUT_RDY) begin
            log_dat.push_back(OUT_DAT);
            log_last.push_back(OUT_LAST);
            log_cyc.push_back(cyc);
        end
        if (!rst && IN_VLD && IN_RDY) acc_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [DIN-1:0] d, input logic l, input int maxc);
        bit acc = 0;
        IN_DAT = d;
        IN_LAST = l;
        IN_VLD = 1'b1;
        for (int i = 0; i < maxc && !acc; i++) begin
            @(negedge clk);
            acc = IN_RDY;
            sync();
        end
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_word_timeout: got no accept expected accept within %0d cycles", maxc);
        end
    endtask

    task automatic wait_idle(input int maxc);
        bit done = 0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (!BUSY) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got BUSY=1 expected BUSY=0 within %0d cycles", maxc);
        end
        sync();
    endtask

    function automatic logic [DIN-1:0] mkword(input int i);
        logic [DOUT-1:0] hi, lo;
        hi = 128'hB0 + 128'(i);
        lo = 128'hA0 + 128'(i);
        return {hi, lo};
    endfunction

    int n_last;
    logic [DOUT-1:0] exp_beats[8];

    initial begin
        rst = 1'b1;
        IN_VLD = 1'b1;
        IN_DAT = {128'h1111, 128'h2222};
        IN_LAST = 1'b1;
        OUT_RDY = 1'b0;

        // reset / idle: IN_VLD high during reset must not capture anything
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        IN_VLD = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy",  IN_RDY,  1'b1);
        chk("rst_out_vld", OUT_VLD, 1'b0);
        chk("rst_busy",    BUSY,    1'b0);
        chk("rst_out_dat", OUT_DAT, '0);
        sync();

        // single word, R=2
        IN_DAT = {128'hB, 128'hA};
        IN_LAST = 1'b1;
        IN_VLD = 1'b1;
        OUT_RDY = 1'b1;
        sync();
        IN_VLD = 1'b0;
        @(negedge clk);
        chk("single_vld1", OUT_VLD, 1'b1);
`ifdef ITF_PISO_MSB_FIRST_EN
        chk("single_beat1", OUT_DAT, 128'hB);
`else
        chk("single_beat1", OUT_DAT, 128'hA);
`endif
        chk("single_last1", OUT_LAST, 1'b0);
        sync();
        @(negedge clk);
`ifdef ITF_PISO_MSB_FIRST_EN
        chk("single_beat2", OUT_DAT, 128'hA);
`else
        chk("single_beat2", OUT_DAT, 128'hB);
`endif
        chk("single_last2", OUT_LAST, 1'b1);
        sync();
        @(negedge clk);
        chk("single_busy_after", BUSY, 1'b0);
        sync();

        // back-pressure, then full with simultaneous retire
        OUT_RDY = 1'b0;
        log_dat.delete(); log_last.delete(); log_cyc.delete();
        acc_cnt = 0;
        send_word(mkword(0), 1'b0, 10);
        send_word(mkword(1), 1'b0, 10);
        IN_DAT = mkword(2);
        IN_LAST = 1'b0;
        IN_VLD = 1'b1;
        repeat (4) sync();
        @(negedge clk);
        chk("bp_accepted", 128'(acc_cnt), 128'd2);
        chk("bp_in_rdy", IN_RDY, 1'b0);
`ifdef ITF_PISO_MSB_FIRST_EN
        chk("bp_hold_dat", OUT_DAT, 128'hB0);
`else
        chk("bp_hold_dat", OUT_DAT, 128'hA0);
`endif
        sync();
        OUT_RDY = 1'b1;
        @(negedge clk);
        chk("full_in_rdy_k0", IN_RDY, 1'b0);
        sync();
        @(negedge clk);
        chk("full_in_rdy_retire", IN_RDY, 1'b0);
        sync();
        @(negedge clk);
        chk("full_in_rdy_after", IN_RDY, 1'b1);
        chk("full_no_accept", 128'(acc_cnt), 128'd2);
        sync();
        send_word(mkword(3), 1'b1, 20);
        IN_VLD = 1'b0;
        wait_idle(20);
`ifdef ITF_PISO_MSB_FIRST_EN
        exp_beats = '{128'hB0, 128'hA0, 128'hB1, 128'hA1, 128'hB2, 128'hA2, 128'hB3, 128'hA3};
`else
        exp_beats = '{128'hA0, 128'hB0, 128'hA1, 128'hB1, 128'hA2, 128'hB2, 128'hA3, 128'hB3};
`endif
        chk("bp_beat_count", 128'(log_dat.size()), 128'd8);
        if (log_dat.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("bp_beat%0d_dat", j), log_dat[j], exp_beats[j]);
                chk($sformatf("bp_beat%0d_last", j), log_last[j], (j == 7));
            end
            chk("bp_no_bubble", 128'(log_cyc[7] - log_cyc[0]), 128'd7);
        end

        // reset mid-transfer: LAST word discarded after its first beat
        log_dat.delete(); log_last.delete(); log_cyc.delete();
        OUT_RDY = 1'b1;
        send_word({128'hD, 128'hC}, 1'b1, 10);
        IN_VLD = 1'b0;
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_vld", OUT_VLD, 1'b0);
        chk("midrst_busy",    BUSY,    1'b0);
        chk("midrst_in_rdy",  IN_RDY,  1'b1);
        sync();
        repeat (3) sync();
        chk("midrst_beats", 128'(log_dat.size()), 128'd1);
        n_last = 0;
        foreach (log_last[j]) if (log_last[j]) n_last++;
        chk("midrst_no_last", 128'(n_last), 128'd0);

        // back-to-back transfers under toggling back-pressure
        log_dat.delete(); log_last.delete(); log_cyc.delete();
        fork
            begin
                send_word(mkword(4), 1'b0, 30);
                send_word(mkword(5), 1'b1, 30);
                send_word(mkword(6), 1'b1, 30);
                IN_VLD = 1'b0;
            end
            begin
                logic [11:0] pat;
                pat = 12'b1011_0100_1110;
                for (int i = 0; i < 12; i++) begin
                    OUT_RDY = pat[i];
                    sync();
                end
            end
        join
        OUT_RDY = 1'b1;
        wait_idle(30);
        chk("b2b_beats", 128'(log_dat.size()), 128'd6);
        n_last = 0;
        foreach (log_last[j]) if (log_last[j]) n_last++;
        chk("b2b_lasts", 128'(n_last), 128'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
